parking_slot_counter: RTL and testbench
=======================================

# parking_slot_counter

Counts occupied parking slots from raw entry/exit pushbuttons and produces the occupied (`Occ`) and free (`Liv`) single-digit values consumed by the display digit multiplexer. It synchronises and debounces both buttons, converts each press into a one-cycle event, and maintains a saturating occupancy count with full/empty/error flags. It sits between the board push-buttons and the display path.

## Interface
- `CAPACITY`, default 9: number of slots; legal range 1..9, so each output is one decimal digit.
- `DEB_CYCLES`, default 500000: consecutive stable cycles required to accept a button level change. This is 10 ms at 50 MHz; legal range ≥ 2. The counter width is derived internally with `$clog2`.
- `Clk` input 1: system clock; all state updates on its rising edge.
- `Rst_n` input 1: reset, asynchronous, active-low.
- `Entry_n` input 1: raw entry button, active-low, asynchronous to `Clk`, bouncy.
- `Exit_n` input 1: raw exit button, active-low, asynchronous to `Clk`, bouncy.
- `Occ` output 4: occupied slots, 0..CAPACITY, registered.
- `Liv` output 4: free slots, equal to CAPACITY − `Occ`, registered.
- `Full` output 1: high when `Occ` == CAPACITY, registered.
- `Empty` output 1: high when `Occ` == 0, registered.
- `Err` output 1: one-cycle pulse when a press is rejected, registered.

## Operation
- **Reset values:** `Occ`=0, `Liv`=CAPACITY, `Empty`=1, `Full`=0, `Err`=0.
- **Reset of internal state:** synchroniser FFs=1, debounced levels=1 (released), debounce counters=0.
- **Reset mid-operation:** any count and any press in progress are discarded. A button held through reset release must be debounced again before it can produce an event.
- **Synchroniser:** each button passes through its own 2-FF synchroniser, `sync1` then `sync2`.
- **Debounce, per button:**
  - A stable level register and a counter.
  - While `sync2` ≠ stable level, the counter increments each cycle.
  - When `sync2` == stable level, the counter clears to 0.
  - When the counter reaches DEB_CYCLES−1 while still mismatched, the stable level takes `sync2` on that edge and the counter clears.
  - Any bounce back to the old level before that point restarts the count.
- **Event generation:** an event is the 1→0 transition of the stable level (a press). Releases generate nothing. Each press gives exactly one event however long it is held.
- **Count update** (registered, on the cycle after the event), by case:
  - Entry only and `Occ` < CAPACITY: `Occ`+1.
  - Entry only and `Full`: no change, `Err`=1 for one cycle.
  - Exit only and `Occ` > 0: `Occ`−1.
  - Exit only and `Empty`: no change, `Err`=1 for one cycle.
  - Entry and exit events in the same cycle: no change, `Err`=0. This applies at any count, including full and empty.
- **Output consistency:** `Liv`, `Full` and `Empty` are always updated on the same edge as `Occ`. Their relationship with `Occ` holds every cycle.
- **Range:** `Occ` never wraps and never exceeds CAPACITY.

## Timing
- Edge 1 is the first rising edge that samples a raw input low.
  - `sync2` goes low at edge 2.
  - The stable level falls at edge DEB_CYCLES+2.
  - `Occ`/`Liv`/`Full`/`Empty`/`Err` change at edge DEB_CYCLES+3.
- This assumes the input stays low throughout. Any high sample resets the debounce count.
- `Err` is high for exactly one cycle per rejected press.
- Back-to-back presses need at least DEB_CYCLES cycles released between them. Shorter gaps are treated as bounce.
- Outputs are glitch-free (direct register outputs). They are safe to feed the combinational digit mux.
- Entry and exit paths are fully independent. Differing press timings yield separate events processed in their own cycles.

## Test plan
All scenarios use CAPACITY=3 and DEB_CYCLES=4.
- **Reset:** assert `Rst_n`=0 mid-clock → immediately `Occ`=0, `Liv`=3, `Empty`=1, `Full`=0, `Err`=0; hold low for 3 cycles, release, values unchanged.
- **Clean entry:** hold `Entry_n` low for 10 cycles → `Occ`=1 and `Liv`=2 exactly at edge 7; `Empty` falls at the same edge; no further change while held.
- **Bounce rejection:** toggle `Entry_n` low 3 cycles / high 1 cycle, repeated 5 times, then high → `Occ` stays 0, `Err` stays 0.
- **Saturate full:** 4 clean entries → `Occ` 1,2,3,3; `Full`=1 after the third; fourth gives `Err` high for exactly one cycle and `Liv`=0.
- **Underflow:** from reset, one clean exit → `Occ`=0, one-cycle `Err` pulse, `Empty` stays 1.
- **Simultaneous:** at `Occ`=3, press `Entry_n` and `Exit_n` on the same edge → `Occ`=3, `Err`=0; then a lone exit → `Occ`=2, `Full`=0; assert reset during a held press → counts cleared, no event after release of reset until re-debounced.

Source files
------------

// File: rtl/parking_slot_counter_if.sv
// Button and display-value bundle for parking_slot_counter.
//   Entry_n, Exit_n : raw active-low push-buttons (asynchronous, bouncy)
//   Occ, Liv        : occupied / free slot digits
//   Full, Empty     : occupancy flags
//   Err             : one-cycle pulse on a rejected press
interface parking_slot_counter_if;
  logic       Entry_n;
  logic       Exit_n;
  logic [3:0] Occ;
  logic [3:0] Liv;
  logic       Full;
  logic       Empty;
  logic       Err;

  // Counter side: consumes buttons, produces display values.
  modport slave (
    input  Entry_n, Exit_n,
    output Occ, Liv, Full, Empty, Err
  );

  // Board/display side: drives buttons, observes values.
  modport master (
    output Entry_n, Exit_n,
    input  Occ, Liv, Full, Empty, Err
  );
endinterface

// File: rtl/parking_slot_counter.sv
// Occupancy counter for a small car park. Each raw button is synchronised,
// debounced, and turned into a single press event; the count saturates at
// 0 and CAPACITY and flags rejected presses with a one-cycle Err pulse.
//   Clk   : system clock, rising edge
//   Rst_n : asynchronous active-low reset
//   bus   : buttons in, Occ/Liv/Full/Empty/Err out (all registered)
module parking_slot_counter #(
  parameter int unsigned CAPACITY   = 9,
  parameter int unsigned DEB_CYCLES = 500000
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  parking_slot_counter_if.slave bus
);

  localparam int unsigned CNT_W   = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);
  localparam logic [3:0]       CAP     = 4'(CAPACITY);

  // Index 0 = entry button, index 1 = exit button.
  logic [1:0]            raw;
  logic [1:0]            sync1;
  logic [1:0]            sync2;
  logic [1:0]            stable;
  logic [1:0]            stable_nxt;
  logic [1:0]            stable_d1;
  logic [1:0][CNT_W-1:0] cnt;
  logic [1:0][CNT_W-1:0] cnt_nxt;
  logic [1:0]            press;

  logic [3:0] occ;
  logic [3:0] occ_nxt;
  logic [3:0] liv;
  logic       full;
  logic       empty;
  logic       err;
  logic       err_nxt;

  assign raw = {bus.Exit_n, bus.Entry_n};

  // Debounce: count consecutive mismatching cycles, accept the new level
  // on the edge where the count has reached DEB_CYCLES-1.
  always_comb begin
    stable_nxt = stable;
    cnt_nxt    = cnt;
    for (int i = 0; i < 2; i++) begin
      if (sync2[i] == stable[i]) begin
        cnt_nxt[i] = '0;
      end else if (cnt[i] == CNT_MAX) begin
        stable_nxt[i] = sync2[i];
        cnt_nxt[i]    = '0;
      end else begin
        cnt_nxt[i] = cnt[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sync1     <= '1;
      sync2     <= '1;
      stable    <= '1;
      stable_d1 <= '1;
      cnt       <= '0;
    end else begin
      sync1     <= raw;
      sync2     <= sync1;
      stable    <= stable_nxt;
      stable_d1 <= stable;
      cnt       <= cnt_nxt;
    end
  end

  // A press is the falling edge of the debounced level; releases are ignored.
  assign press = stable_d1 & ~stable;

  // Saturating count update; simultaneous entry+exit cancel without error.
  always_comb begin
    occ_nxt = occ;
    err_nxt = 1'b0;
    unique case (press)
      2'b01: begin
        if (occ < CAP) occ_nxt = occ + 4'd1;
        else           err_nxt = 1'b1;
      end
      2'b10: begin
        if (occ != 4'd0) occ_nxt = occ - 4'd1;
        else             err_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  // Derived flags are registered from occ_nxt so they move with Occ.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      occ   <= 4'd0;
      liv   <= CAP;
      full  <= 1'b0;
      empty <= 1'b1;
      err   <= 1'b0;
    end else begin
      occ   <= occ_nxt;
      liv   <= CAP - occ_nxt;
      full  <= (occ_nxt == CAP);
      empty <= (occ_nxt == 4'd0);
      err   <= err_nxt;
    end
  end

  assign bus.Occ   = occ;
  assign bus.Liv   = liv;
  assign bus.Full  = full;
  assign bus.Empty = empty;
  assign bus.Err   = err;

endmodule

// File: tb/tb_parking_slot_counter.sv
// Directed bench for parking_slot_counter with CAPACITY=3, DEB_CYCLES=4.
module tb_parking_slot_counter;

  localparam int unsigned CAP = 3;
  localparam int unsigned DEB = 4;

  logic Clk;
  logic Rst_n;

  parking_slot_counter_if bus ();

  parking_slot_counter #(
    .CAPACITY   (CAP),
    .DEB_CYCLES (DEB)
  ) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus.slave)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit ent;
    bit ext;
    int occ;
    int liv;
    int full;
    int empty;
    int errs;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " Occ"},   int'(bus.Occ),   0);
    check({tag, " Liv"},   int'(bus.Liv),   int'(CAP));
    check({tag, " Empty"}, int'(bus.Empty), 1);
    check({tag, " Full"},  int'(bus.Full),  0);
    check({tag, " Err"},   int'(bus.Err),   0);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    #2 Rst_n = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
  endtask

  // Hold the selected buttons for 10 cycles, release for 10, counting Err-high cycles.
  task automatic press(input bit ent, input bit ext, output int errs);
    errs = 0;
    @(negedge Clk);
    bus.Entry_n = ~ent;
    bus.Exit_n  = ~ext;
    repeat (10) begin
      @(posedge Clk); #1;
      errs += int'(bus.Err);
    end
    @(negedge Clk);
    bus.Entry_n = 1'b1;
    bus.Exit_n  = 1'b1;
    repeat (10) begin
      @(posedge Clk); #1;
      errs += int'(bus.Err);
    end
  endtask

  initial begin
    int errs;
    int occ_seen;

    // ent ext occ liv full empty errs
    tbl[0] = '{1'b1, 1'b0, 1, 2, 0, 0, 0};
    tbl[1] = '{1'b1, 1'b0, 2, 1, 0, 0, 0};
    tbl[2] = '{1'b1, 1'b0, 3, 0, 1, 0, 0};
    tbl[3] = '{1'b1, 1'b0, 3, 0, 1, 0, 1};
    tbl[4] = '{1'b1, 1'b1, 3, 0, 1, 0, 0};
    tbl[5] = '{1'b0, 1'b1, 2, 1, 0, 0, 0};
    tbl[6] = '{1'b0, 1'b1, 1, 2, 0, 0, 0};
    tbl[7] = '{1'b0, 1'b1, 0, 3, 0, 1, 0};
    tbl[8] = '{1'b0, 1'b1, 0, 3, 0, 1, 1};
    tbl[9] = '{1'b1, 1'b1, 0, 3, 0, 1, 0};

    Rst_n       = 1'b1;
    bus.Entry_n = 1'b1;
    bus.Exit_n  = 1'b1;

    // Reset asserted mid-clock takes effect immediately and holds after release.
    #12 Rst_n = 1'b0;
    #1 check_reset_vals("rst_async");
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    @(posedge Clk); #1;
    check_reset_vals("rst_release");

    // Clean entry: Occ must change exactly at edge DEB+3 = 7 and then hold.
    @(negedge Clk);
    bus.Entry_n = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge Clk); #1;
      check($sformatf("clean edge%0d Occ", k),   int'(bus.Occ),   (k >= 7) ? 1 : 0);
      check($sformatf("clean edge%0d Liv", k),   int'(bus.Liv),   (k >= 7) ? 2 : 3);
      check($sformatf("clean edge%0d Empty", k), int'(bus.Empty), (k >= 7) ? 0 : 1);
    end
    @(negedge Clk);
    bus.Entry_n = 1'b1;
    repeat (10) @(posedge Clk);
    #1 check("clean after release Occ", int'(bus.Occ), 1);

    // Bounce: 3 low / 1 high never reaches the debounce threshold.
    do_reset();
    errs     = 0;
    occ_seen = 0;
    for (int r = 0; r < 5; r++) begin
      @(negedge Clk);
      bus.Entry_n = 1'b0;
      repeat (3) begin
        @(posedge Clk); #1;
        errs += int'(bus.Err);
        if (bus.Occ != 4'd0) occ_seen++;
      end
      @(negedge Clk);
      bus.Entry_n = 1'b1;
      @(posedge Clk); #1;
      errs += int'(bus.Err);
      if (bus.Occ != 4'd0) occ_seen++;
    end
    repeat (10) begin
      @(posedge Clk); #1;
      errs += int'(bus.Err);
      if (bus.Occ != 4'd0) occ_seen++;
    end
    check("bounce Occ nonzero cycles", occ_seen, 0);
    check("bounce Err cycles", errs, 0);

    // Press sequence table from empty.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      press(tbl[i].ent, tbl[i].ext, errs);
      check($sformatf("row%0d Occ", i),   int'(bus.Occ),   tbl[i].occ);
      check($sformatf("row%0d Liv", i),   int'(bus.Liv),   tbl[i].liv);
      check($sformatf("row%0d Full", i),  int'(bus.Full),  tbl[i].full);
      check($sformatf("row%0d Empty", i), int'(bus.Empty), tbl[i].empty);
      check($sformatf("row%0d Err cycles", i), errs, tbl[i].errs);
    end

    // Reset during a held press: count cleared, held button re-debounced from scratch.
    press(1'b1, 1'b0, errs);
    check("pre-reset Occ", int'(bus.Occ), 1);
    @(negedge Clk);
    bus.Entry_n = 1'b0;
    repeat (4) @(posedge Clk);
    #2 Rst_n = 1'b0;
    #1 check_reset_vals("rst_held");
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(posedge Clk); #1;
      check($sformatf("held edge%0d Occ", k), int'(bus.Occ), (k >= 7) ? 1 : 0);
    end
    @(negedge Clk);
    bus.Entry_n = 1'b1;
    repeat (10) @(posedge Clk);
    #1 check("held final Occ", int'(bus.Occ), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
